// File: rtl/lbp_pkg.sv
// lbp_pkg: shared types and geometry constants for the LBP histogram stage
// Contents: state_t FSM encoding, bin count, image width, address and code widths.
package lbp_pkg;
  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
  localparam int NUM_BINS = 256;
  localparam int IMG_W    = 128;
  localparam int ADDR_W   = 14;
  localparam int CODE_W   = 8;
endpackage

// File: rtl/lbp_bin_bank.sv
// lbp_bin_bank: NUM_BINS x CNT_W saturating counter array
// Ports: i_clk clock; i_reset sync active-low clear of all bins;
//        i_inc_en/i_inc_idx one saturating increment per cycle;
//        i_rd_idx/o_rd_cnt combinational read of the registered bin value.
module lbp_bin_bank
  import lbp_pkg::*;
#(
  parameter int CNT_W = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_inc_en,
  input  logic [CODE_W-1:0] i_inc_idx,
  input  logic [CODE_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0]  o_rd_cnt
);
  logic [CNT_W-1:0] r_bins [NUM_BINS];
  // Each bin is its own register, so repeated codes on consecutive cycles
  // always see the value written by the previous edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
    end else if (i_inc_en && r_bins[i_inc_idx] != '1) begin
      r_bins[i_inc_idx] <= r_bins[i_inc_idx] + CNT_W'(1);
    end
  end
  assign o_rd_cnt = r_bins[i_rd_idx];
endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin LBP code histogram with valid/ready drain and protocol error flags
// Ports: i_clk clock; i_reset sync active-low reset;
//        i_lbp_valid/i_lbp_addr/i_lbp_data incoming code stream; i_finish end of frame (level);
//        o_hist_valid/i_hist_ready/o_hist_bin/o_hist_count drain port;
//        o_hist_total saturating code total; o_hist_done sticky drain complete;
//        o_hist_err sticky errors (bit0 address order, bit1 code after finish).
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int CNT_W     = 15,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_lbp_valid,
  input  logic [ADDR_W-1:0] i_lbp_addr,
  input  logic [CODE_W-1:0] i_lbp_data,
  input  logic              i_finish,
  output logic              o_hist_valid,
  input  logic              i_hist_ready,
  output logic [CODE_W-1:0] o_hist_bin,
  output logic [CNT_W-1:0]  o_hist_count,
  output logic [CNT_W-1:0]  o_hist_total,
  output logic              o_hist_done,
  output logic [1:0]        o_hist_err
);
  localparam logic [CODE_W-1:0] LAST_BIN = CODE_W'(NUM_BINS - 1);
  state_t              r_state;
  logic [CODE_W-1:0]   r_ptr;
  logic                r_valid;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_total;
  logic                r_done;
  logic [1:0]          r_err;
  logic [ADDR_W-1:0]   r_last;
  logic                r_first;
  logic                w_inc;
  logic [CODE_W-1:0]   w_rd_idx;
  logic [CNT_W-1:0]    w_rd_cnt;
  logic                w_skip;
  assign w_inc    = i_lbp_valid && r_state == ACCUM;
  // While a beat is on the port, look ahead at the next bin so an acceptance
  // can load it on the same edge and sustain one bin per cycle.
  assign w_rd_idx = r_valid ? r_ptr + CODE_W'(1) : r_ptr;
  assign w_skip   = SKIP_ZERO && w_rd_cnt == '0;
  lbp_bin_bank #(.CNT_W(CNT_W)) u_bank (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_inc_en  (w_inc),
    .i_inc_idx (i_lbp_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_cnt  (w_rd_cnt)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ACCUM;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_total <= '0;
      r_done  <= 1'b0;
      r_err   <= '0;
      r_last  <= '0;
      r_first <= 1'b1;
    end else begin
      if (i_lbp_valid && r_state != ACCUM) r_err[1] <= 1'b1;
      case (r_state)
        ACCUM: begin
          if (i_lbp_valid) begin
            if (!r_first && i_lbp_addr <= r_last) r_err[0] <= 1'b1;
            r_last  <= i_lbp_addr;
            r_first <= 1'b0;
            if (r_total != '1) r_total <= r_total + CNT_W'(1);
          end
          if (i_finish) r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_valid && i_hist_ready && r_ptr == LAST_BIN) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_valid && i_hist_ready) begin
            // A zero next bin drops valid; the idle branch then steps past it.
            r_ptr   <= w_rd_idx;
            r_valid <= !w_skip;
            r_count <= w_rd_cnt;
          end else if (!r_valid) begin
            if (!w_skip) begin
              r_valid <= 1'b1;
              r_count <= w_rd_cnt;
            end else if (r_ptr == LAST_BIN) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_ptr <= r_ptr + CODE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
  assign o_hist_valid = r_valid;
  assign o_hist_bin   = r_ptr;
  assign o_hist_count = r_count;
  assign o_hist_total = r_total;
  assign o_hist_done  = r_done;
  assign o_hist_err   = r_err;
endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: directed and randomized frames checked against a bin-count model
module tb_lbp_hist;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, lv, fin, rdy;
  logic [13:0] la;
  logic [7:0] ld;
  logic v0, v1, v2, d0, d1, d2;
  logic [7:0] b0, b1, b2;
  logic [14:0] c0, c1, t0, t1;
  logic [3:0] c2, t2;
  logic [1:0] e0, e1, e2;
  logic v[3], dn[3];
  logic [7:0] b[3];
  logic [14:0] c[3], t[3];
  logic [1:0] e[3];
  assign v  = '{v0, v1, v2};
  assign dn = '{d0, d1, d2};
  assign b  = '{b0, b1, b2};
  assign c  = '{c0, c1, {11'b0, c2}};
  assign t  = '{t0, t1, {11'b0, t2}};
  assign e  = '{e0, e1, e2};
  lbp_hist u0 (.i_clk(clk), .i_reset(rst_n), .i_lbp_valid(lv), .i_lbp_addr(la), .i_lbp_data(ld),
    .i_finish(fin), .o_hist_valid(v0), .i_hist_ready(rdy), .o_hist_bin(b0), .o_hist_count(c0),
    .o_hist_total(t0), .o_hist_done(d0), .o_hist_err(e0));
  lbp_hist #(.SKIP_ZERO(1'b1)) u1 (.i_clk(clk), .i_reset(rst_n), .i_lbp_valid(lv), .i_lbp_addr(la),
    .i_lbp_data(ld), .i_finish(fin), .o_hist_valid(v1), .i_hist_ready(rdy), .o_hist_bin(b1),
    .o_hist_count(c1), .o_hist_total(t1), .o_hist_done(d1), .o_hist_err(e1));
  lbp_hist #(.CNT_W(4)) u2 (.i_clk(clk), .i_reset(rst_n), .i_lbp_valid(lv), .i_lbp_addr(la),
    .i_lbp_data(ld), .i_finish(fin), .o_hist_valid(v2), .i_hist_ready(rdy), .o_hist_bin(b2),
    .o_hist_count(c2), .o_hist_total(t2), .o_hist_done(d2), .o_hist_err(e2));
  int q[3][$];
  int stall[3];
  logic pv[3];
  logic [7:0] pb[3];
  logic [14:0] pc[3];
  logic pr;
  // Inputs change just after posedge, so values seen at negedge are what the next edge samples.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        q[k].delete();
        stall[k] = 0;
        pv[k] = 1'b0;
      end else begin
        if (pv[k] && !pr && !(v[k] === 1'b1 && b[k] === pb[k] && c[k] === pc[k])) stall[k]++;
        if (v[k] && rdy) q[k].push_back(int'(b[k]) * 65536 + int'(c[k]));
        pv[k] = v[k];
        pb[k] = b[k];
        pc[k] = c[k];
      end
    end
    pr = rdy;
  end
  int m_bins[256];
  int m_total;
  logic m_err0, m_err1, m_first;
  logic [13:0] m_last;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_bins[i] = 0;
    m_total = 0;
    m_err0 = 1'b0;
    m_err1 = 1'b0;
    m_first = 1'b1;
    m_last = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    lv = 1'b0;
    fin = 1'b0;
    rdy = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    model_clear();
  endtask
  task automatic check_idle(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_u%0d_valid", tag, k), 32'(v[k]), 0);
      chk($sformatf("%s_u%0d_bin", tag, k), 32'(b[k]), 0);
      chk($sformatf("%s_u%0d_count", tag, k), 32'(c[k]), 0);
      chk($sformatf("%s_u%0d_total", tag, k), 32'(t[k]), 0);
      chk($sformatf("%s_u%0d_done", tag, k), 32'(dn[k]), 0);
      chk($sformatf("%s_u%0d_err", tag, k), 32'(e[k]), 0);
    end
  endtask
  task automatic send(input logic [13:0] a, input logic [7:0] d, input logic f);
    lv = 1'b1;
    la = a;
    ld = d;
    fin = f;
    m_bins[d]++;
    m_total++;
    if (!m_first && a <= m_last) m_err0 = 1'b1;
    m_last = a;
    m_first = 1'b0;
    tick();
    lv = 1'b0;
    fin = 1'b0;
  endtask
  task automatic do_finish();
    fin = 1'b1;
    tick();
    fin = 1'b0;
  endtask
  task automatic drain(input int mode, input bit inj, input bit hold, output int n0);
    int n = 0;
    n0 = 0;
    while (!(dn[0] && dn[1] && dn[2]) && n < 3000) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? n[0] : 1'($urandom_range(0, 1));
      fin = hold;
      if (inj && n == 6) begin
        lv = 1'b1;
        la = 14'($urandom);
        ld = 8'($urandom);
        m_err1 = 1'b1;
      end
      tick();
      lv = 1'b0;
      n++;
      if (dn[0] && n0 == 0) n0 = n;
    end
    fin = 1'b0;
    rdy = 1'b1;
    chk("drain_complete", 32'(dn[0] && dn[1] && dn[2]), 1);
  endtask
  task automatic check_frame(input string tag);
    for (int k = 0; k < 3; k++) begin
      int ex[$];
      int wmax = k == 2 ? 15 : 32767;
      int nmis = 0;
      for (int i = 0; i < 256; i++) begin
        int cnt = m_bins[i] > wmax ? wmax : m_bins[i];
        if (k != 1 || cnt != 0) ex.push_back(i * 65536 + cnt);
      end
      for (int i = 0; i < ex.size() && i < q[k].size(); i++) if (q[k][i] != ex[i]) nmis++;
      chk($sformatf("%s_u%0d_beats", tag, k), q[k].size(), ex.size());
      chk($sformatf("%s_u%0d_beat_mismatches", tag, k), nmis, 0);
      chk($sformatf("%s_u%0d_stall_violations", tag, k), stall[k], 0);
      chk($sformatf("%s_u%0d_total", tag, k), 32'(t[k]), m_total > wmax ? wmax : m_total);
      chk($sformatf("%s_u%0d_done", tag, k), 32'(dn[k]), 1);
      chk($sformatf("%s_u%0d_valid_after_done", tag, k), 32'(v[k]), 0);
      chk($sformatf("%s_u%0d_err", tag, k), 32'(e[k]), {m_err1, m_err0});
    end
  endtask
  initial begin
    int n0, n;
    logic [13:0] a;
    la = '0;
    ld = '0;
    do_reset();
    check_idle("reset");
    send(14'd129, 8'h00, 1'b0);
    send(14'd130, 8'hFF, 1'b0);
    send(14'd131, 8'h00, 1'b0);
    send(14'd132, 8'h5A, 1'b0);
    do_finish();
    @(negedge clk);
    chk("latency_not_yet_valid", 32'(v0), 0);
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(v0), 1);
    chk("latency_bin0", 32'(b0), 0);
    chk("latency_bin0_count", 32'(c0), 2);
    drain(0, 1'b0, 1'b0, n0);
    chk("drain_cycles_u0", n0, 256);
    check_frame("count");
    do_reset();
    do_finish();
    drain(0, 1'b0, 1'b0, n0);
    check_frame("empty");
    do_reset();
    for (int i = 0; i < 10; i++) send(14'(10 + i), 8'h33, 1'b0);
    for (int i = 0; i < 20; i++) send(14'(100 + 2 * i), 8'($urandom), i == 19);
    drain(1, 1'b0, 1'b0, n0);
    check_frame("b2b_toggle");
    do_reset();
    send(14'd200, 8'h11, 1'b0);
    send(14'd150, 8'h22, 1'b0);
    send(14'd300, 8'h11, 1'b0);
    do_finish();
    drain(2, 1'b1, 1'b1, n0);
    check_frame("errors");
    do_reset();
    send(14'd5, 8'd3, 1'b0);
    send(14'd6, 8'd7, 1'b0);
    do_finish();
    drain(0, 1'b0, 1'b0, n0);
    check_frame("skip");
    do_reset();
    for (int i = 0; i < 20; i++) send(14'(i), 8'h02, 1'b0);
    do_finish();
    drain(2, 1'b0, 1'b0, n0);
    check_frame("saturate");
    for (int f = 0; f < 3; f++) begin
      do_reset();
      a = 14'($urandom_range(0, 3));
      n = $urandom_range(50, 400);
      for (int i = 0; i < n; i++) begin
        send(a, $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 7)) : 8'($urandom), 1'b0);
        a = $urandom_range(0, 19) == 0 ? a - 14'($urandom_range(0, 2)) : a + 14'($urandom_range(1, 3));
      end
      do_finish();
      drain(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n0);
      check_frame($sformatf("random%0d", f));
    end
    do_reset();
    for (int i = 0; i < 40; i++) send(14'(i), 8'($urandom), 1'b0);
    do_finish();
    n = 0;
    while (!(v0 && b0 == 8'd100) && n < 400) begin
      tick();
      n++;
    end
    chk("reached_bin100", 32'(v0 && b0 == 8'd100), 1);
    rst_n = 1'b0;
    tick();
    check_idle("mid_drain_reset");
    rst_n = 1'b1;
    model_clear();
    send(14'd7, 8'h01, 1'b0);
    do_finish();
    drain(0, 1'b0, 1'b0, n0);
    check_frame("after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
